alarm_clk_buttons: RTL and testbench

Avalon-MM slave input port for the alarm clock's push-buttons (set hour, set minute, alarm on/off, snooze). It is the input-direction counterpart of the clock's output digit ports. It synchronizes and debounces the raw key pins and latches press events in a write-to-clear edge-capture register. It raises a maskable interrupt to the Nios II processor.

---
 rtl/alarm_clk_buttons.sv | 129 ++++++++++++
 tb/tb_alarm_clk_buttons.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_clk_buttons.sv
// Avalon-MM push-button input port: synchronizer, debounce, press capture (W1C) and maskable irq.
// Define ALARM_CLK_BUTTONS_DEBOUNCE_EN to build the per-bit debounce counters; otherwise sync2 is accepted directly.
module alarm_clk_buttons #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] stableDly_q;
    logic [WIDTH-1:0] irqMask_q;
    logic [WIDTH-1:0] edgeCap_q;
    logic [WIDTH-1:0] edgeCap_d;
    logic [WIDTH-1:0] clearMask;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] activeDly;
    logic [WIDTH-1:0] press;
    logic             writeEn;
    logic             unusedWriteBits;

    assign writeEn         = chipselect && !write_n;
    assign unusedWriteBits = ^writedata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

`ifdef ALARM_CLK_BUTTONS_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // A level is accepted only after it differs from stable for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    assign stable_d = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable_q    <= IDLE;
            stableDly_q <= IDLE;
        end else begin
            stable_q    <= stable_d;
            stableDly_q <= stable_q;
        end
    end

    // Only idle-to-active transitions are events; a set in the same cycle as a clear wins.
    always_comb begin
        active    = stable_q ^ IDLE;
        activeDly = stableDly_q ^ IDLE;
        press     = active & ~activeDly;
        clearMask = (writeEn && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        edgeCap_d = (edgeCap_q & ~clearMask) | press;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edgeCap_q <= '0;
            irqMask_q <= '0;
        end else begin
            edgeCap_q <= edgeCap_d;
            if (writeEn && address == 2'd2) begin
                irqMask_q <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = stable_q;
            2'd2:    readdata[WIDTH-1:0] = irqMask_q;
            2'd3:    readdata[WIDTH-1:0] = edgeCap_q;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edgeCap_q & irqMask_q);

endmodule

// File: tb/tb_alarm_clk_buttons.sv
// Directed self-checking bench for alarm_clk_buttons (WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
// Expected latencies follow ALARM_CLK_BUTTONS_DEBOUNCE_EN: effective debounce length 4 when defined, 1 otherwise.
module tb_alarm_clk_buttons;

`ifdef ALARM_CLK_BUTTONS_DEBOUNCE_EN
    localparam int DEB = 4;
    localparam logic [31:0] GLITCH_EC = 32'h2;
`else
    localparam int DEB = 1;
    localparam logic [31:0] GLITCH_EC = 32'h3;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks;
    int failures;
    logic [31:0] rd;

    alarm_clk_buttons #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pins);
        in_port = pins;
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        write_n    = 1'b1;
        chipselect = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'hF;

        // Reset state
        tick(3);
        reset_n = 1'b1;
        readReg(2'd0, rd); checkOutput("reset_data", rd, 32'hF);
        readReg(2'd1, rd); checkOutput("reset_reserved", rd, 32'h0);
        readReg(2'd2, rd); checkOutput("reset_mask", rd, 32'h0);
        readReg(2'd3, rd); checkOutput("reset_edgecap", rd, 32'h0);
        checkOutput("reset_irq", {31'b0, irq}, 32'h0);

        // Press bit 1: sampled at edge k, DATA at k+1+DEB, EDGECAPTURE at k+2+DEB
        applyStimulus(4'hD);
        tick(1 + DEB);
        readReg(2'd0, rd); checkOutput("press_data_before", rd, 32'hF);
        tick(1);
        readReg(2'd0, rd); checkOutput("press_data_after", rd, 32'hD);
        readReg(2'd3, rd); checkOutput("press_ec_before", rd, 32'h0);
        tick(1);
        readReg(2'd3, rd); checkOutput("press_ec_after", rd, 32'h2);
        checkOutput("press_irq_masked", {31'b0, irq}, 32'h0);
        writeReg(2'd2, 32'h2);
        checkOutput("press_irq_unmasked", {31'b0, irq}, 32'h1);
        readReg(2'd2, rd); checkOutput("mask_readback", rd, 32'h2);

        // Three-cycle glitch on bit 0
        applyStimulus(4'hC);
        tick(3);
        applyStimulus(4'hD);
        tick(8);
        readReg(2'd0, rd); checkOutput("glitch_data", rd, 32'hD);
        readReg(2'd3, rd); checkOutput("glitch_ec", rd, GLITCH_EC);

        // Release is not captured
        applyStimulus(4'hF);
        tick(DEB + 4);
        readReg(2'd0, rd); checkOutput("release_data", rd, 32'hF);
        readReg(2'd3, rd); checkOutput("release_ec", rd, GLITCH_EC);
        writeReg(2'd3, 32'hF);
        readReg(2'd3, rd); checkOutput("clear_all_ec", rd, 32'h0);
        checkOutput("clear_all_irq", {31'b0, irq}, 32'h0);

        // W1C with EDGECAPTURE=0x6, IRQMASK=0xF
        applyStimulus(4'h9);
        tick(DEB + 3);
        readReg(2'd3, rd); checkOutput("w1c_start_ec", rd, 32'h6);
        writeReg(2'd2, 32'hF);
        writeReg(2'd3, 32'h2);
        readReg(2'd3, rd); checkOutput("w1c_first_ec", rd, 32'h4);
        checkOutput("w1c_first_irq", {31'b0, irq}, 32'h1);
        writeReg(2'd3, 32'h4);
        readReg(2'd3, rd); checkOutput("w1c_second_ec", rd, 32'h0);
        checkOutput("w1c_second_irq", {31'b0, irq}, 32'h0);

        // Set beats clear on bit 3: press lands on the same edge as the W1C write
        applyStimulus(4'h1);
        tick(2 + DEB);
        readReg(2'd3, rd); checkOutput("setclr_ec_before", rd, 32'h0);
        writeReg(2'd3, 32'h8);
        readReg(2'd3, rd); checkOutput("setclr_ec_set_wins", rd, 32'h8);
        checkOutput("setclr_irq", {31'b0, irq}, 32'h1);
        writeReg(2'd3, 32'h8);
        readReg(2'd3, rd); checkOutput("setclr_ec_cleared", rd, 32'h0);

        // Release all, then reset two cycles into a debounce count on bit 0
        applyStimulus(4'hF);
        tick(DEB + 4);
        readReg(2'd3, rd); checkOutput("release_all_ec", rd, 32'h0);
        applyStimulus(4'hE);
        tick(3);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        readReg(2'd0, rd); checkOutput("midreset_data", rd, 32'hF);
        readReg(2'd2, rd); checkOutput("midreset_mask", rd, 32'h0);
        readReg(2'd3, rd); checkOutput("midreset_ec", rd, 32'h0);
        tick(DEB + 2);
        readReg(2'd3, rd); checkOutput("held_ec_before", rd, 32'h0);
        tick(1);
        readReg(2'd3, rd); checkOutput("held_ec_after", rd, 32'h1);
        readReg(2'd0, rd); checkOutput("held_data", rd, 32'hE);
        checkOutput("held_irq_masked", {31'b0, irq}, 32'h0);
        writeReg(2'd2, 32'h1);
        checkOutput("held_irq_unmasked", {31'b0, irq}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
